// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage MIPS32 pipeline: merges decode hazards
// and multi-cycle EX ops into one stall vector, with redirect, watchdog and stall counter.
module pipe_stall_ctrl #(
  parameter int MC_CNT_W  = 6,
  parameter int MAX_STALL = 255,
  parameter int PERF_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                ex_mc_start,
  input  logic [MC_CNT_W-1:0] ex_mc_cycles,
  input  logic                flush_req,
  input  logic [31:0]         flush_pc,
  output logic [5:0]          stall,
  output logic                flush,
  output logic [31:0]         new_pc,
  output logic                ex_mc_busy,
  output logic                ex_mc_last,
  output logic                stall_timeout,
  output logic [PERF_W-1:0]   stall_cycles
);

  localparam int WD_W = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_STALL);
  localparam logic [MC_CNT_W-1:0] MC_ONE = MC_CNT_W'(1);

  typedef enum logic {IDLE, MC_BUSY} state_t;

  state_t              state, state_nx;
  logic [MC_CNT_W-1:0] mc_cnt, mc_cnt_nx, mc_len;
  logic [WD_W-1:0]     wd_cnt;
  logic                stalled;

  assign mc_len  = (ex_mc_cycles == '0) ? MC_ONE : ex_mc_cycles;
  assign stalled = |stall;

  // Outputs are forced low while reset is held, even though reset is asynchronous.
  always_comb begin
    state_nx   = state;
    mc_cnt_nx  = mc_cnt;
    stall      = 6'b000000;
    flush      = 1'b0;
    new_pc     = 32'h0;
    ex_mc_busy = 1'b0;
    ex_mc_last = 1'b0;
    if (rst) begin
      ex_mc_busy = (state == MC_BUSY);
      if (flush_req) begin
        flush     = 1'b1;
        new_pc    = flush_pc;
        state_nx  = IDLE;
        mc_cnt_nx = '0;
      end else if (state == MC_BUSY) begin
        stall      = 6'b001111;
        ex_mc_last = (mc_cnt == MC_ONE);
        mc_cnt_nx  = mc_cnt - MC_ONE;
        if (mc_cnt == MC_ONE) state_nx = IDLE;
      end else if (ex_mc_start) begin
        stall = 6'b001111;
        if (mc_len == MC_ONE) begin
          ex_mc_last = 1'b1;
        end else begin
          state_nx  = MC_BUSY;
          mc_cnt_nx = mc_len - MC_ONE;
        end
      end else if (stallreq_id) begin
        stall = 6'b000111;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      mc_cnt <= '0;
    end else begin
      state  <= state_nx;
      mc_cnt <= mc_cnt_nx;
    end
  end

  // Watchdog counts consecutive stalled cycles; the timeout flag is sticky until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt        <= '0;
      stall_timeout <= 1'b0;
    end else if (stalled) begin
      if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_cnt >= WD_MAX - WD_W'(1)) stall_timeout <= 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (stalled && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed vector table, multi-cycle corner
// sequences and randomized traffic against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;

  localparam int MC_CNT_W  = 6;
  localparam int MAX_STALL = 4;
  localparam int PERF_W    = 8;
  localparam int PERF_MAX  = (1 << PERF_W) - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                stallreq_id;
  logic                ex_mc_start;
  logic [MC_CNT_W-1:0] ex_mc_cycles;
  logic                flush_req;
  logic [31:0]         flush_pc;
  logic [5:0]          stall;
  logic                flush;
  logic [31:0]         new_pc;
  logic                ex_mc_busy;
  logic                ex_mc_last;
  logic                stall_timeout;
  logic [PERF_W-1:0]   stall_cycles;

  pipe_stall_ctrl #(.MC_CNT_W(MC_CNT_W), .MAX_STALL(MAX_STALL), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_start(ex_mc_start),
    .ex_mc_cycles(ex_mc_cycles), .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .ex_mc_busy(ex_mc_busy),
    .ex_mc_last(ex_mc_last), .stall_timeout(stall_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: stall cycles still owed to the running multi-cycle op, consecutive stall run,
  // sticky watchdog flag and total stalled cycles.
  int         m_owed, m_run, m_cyc, m_next_owed;
  bit         m_to;
  logic [5:0] m_stall;

  typedef struct {
    logic [2:0]  req;   // {stallreq_id, ex_mc_start, flush_req}
    logic [5:0]  cy;
    logic [31:0] pc;
    logic [5:0]  e_stall;
    logic [2:0]  e_out; // {flush, ex_mc_busy, ex_mc_last}
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sr, input logic st, input logic [5:0] cy,
                       input logic fl, input logic [31:0] pc);
    stallreq_id  = sr;
    ex_mc_start  = st;
    ex_mc_cycles = cy;
    flush_req    = fl;
    flush_pc     = pc;
  endtask

  // Drive one cycle's inputs, then compare every output with the model.
  task automatic apply(input string tag, input logic sr, input logic st, input logic [5:0] cy,
                       input logic fl, input logic [31:0] pc);
    int          n;
    logic        e_flush, e_busy, e_last;
    logic [31:0] e_pc;
    drive(sr, st, cy, fl, pc);
    #1;
    e_busy = (m_owed > 0); e_flush = 1'b0; e_last = 1'b0; e_pc = 32'h0;
    m_stall = 6'h00; m_next_owed = m_owed;
    if (fl) begin
      e_flush = 1'b1; e_pc = pc; m_next_owed = 0;
    end else if (m_owed > 0) begin
      m_stall = 6'h0F; e_last = (m_owed == 1); m_next_owed = m_owed - 1;
    end else if (st) begin
      n = (cy == 0) ? 1 : int'(cy);
      m_stall = 6'h0F; e_last = (n == 1); m_next_owed = n - 1;
    end else if (sr) begin
      m_stall = 6'h07;
    end
    chk({tag, ".stall"}, 32'(stall), 32'(m_stall));
    chk({tag, ".flush"}, 32'(flush), 32'(e_flush));
    chk({tag, ".new_pc"}, new_pc, e_pc);
    chk({tag, ".busy"}, 32'(ex_mc_busy), 32'(e_busy));
    chk({tag, ".last"}, 32'(ex_mc_last), 32'(e_last));
    chk({tag, ".timeout"}, 32'(stall_timeout), 32'(m_to));
    chk({tag, ".cycles"}, 32'(stall_cycles), 32'(m_cyc));
  endtask

  task automatic advance();
    @(posedge clk);
    if (m_stall != 6'h00) begin
      if (m_run < MAX_STALL) m_run++;
      if (m_run >= MAX_STALL) m_to = 1'b1;
      if (m_cyc < PERF_MAX) m_cyc++;
    end else begin
      m_run = 0;
    end
    m_owed = m_next_owed;
    @(negedge clk);
  endtask

  task automatic step(input string tag, input logic sr, input logic st, input logic [5:0] cy,
                      input logic fl, input logic [31:0] pc);
    apply(tag, sr, st, cy, fl, pc);
    advance();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".stall"}, 32'(stall), 32'h0);
    chk({tag, ".flush"}, 32'(flush), 32'h0);
    chk({tag, ".new_pc"}, new_pc, 32'h0);
    chk({tag, ".busy"}, 32'(ex_mc_busy), 32'h0);
    chk({tag, ".last"}, 32'(ex_mc_last), 32'h0);
    chk({tag, ".timeout"}, 32'(stall_timeout), 32'h0);
    chk({tag, ".cycles"}, 32'(stall_cycles), 32'h0);
  endtask

  // Called at a falling edge; holds reset two cycles with a flush request driven
  // to show the combinational outputs are gated.
  task automatic do_reset(input string tag);
    drive(1'b1, 1'b1, 6'd3, 1'b1, 32'hBFC00380);
    rst = 1'b0;
    #1;
    check_all_zero(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
    m_owed = 0; m_run = 0; m_cyc = 0; m_to = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{3'b000, 6'd0, 32'h0,        6'h00, 3'b000};
    tbl[1]  = '{3'b100, 6'd0, 32'h0,        6'h07, 3'b000};
    tbl[2]  = '{3'b100, 6'd0, 32'h0,        6'h07, 3'b000};
    tbl[3]  = '{3'b010, 6'd5, 32'h0,        6'h0F, 3'b000};
    tbl[4]  = '{3'b000, 6'd0, 32'h0,        6'h0F, 3'b010};
    tbl[5]  = '{3'b000, 6'd0, 32'h0,        6'h0F, 3'b010};
    tbl[6]  = '{3'b000, 6'd0, 32'h0,        6'h0F, 3'b010};
    tbl[7]  = '{3'b000, 6'd0, 32'h0,        6'h0F, 3'b011};
    tbl[8]  = '{3'b000, 6'd0, 32'h0,        6'h00, 3'b000};
    tbl[9]  = '{3'b010, 6'd0, 32'h0,        6'h0F, 3'b001};
    tbl[10] = '{3'b010, 6'd1, 32'h0,        6'h0F, 3'b001};
    tbl[11] = '{3'b000, 6'd0, 32'h0,        6'h00, 3'b000};
    tbl[12] = '{3'b110, 6'd3, 32'h0,        6'h0F, 3'b000};
    tbl[13] = '{3'b110, 6'd7, 32'h0,        6'h0F, 3'b010};
    tbl[14] = '{3'b000, 6'd0, 32'h0,        6'h0F, 3'b011};
    tbl[15] = '{3'b111, 6'd4, 32'h00001234, 6'h00, 3'b100};
    tbl[16] = '{3'b000, 6'd0, 32'h0,        6'h00, 3'b000};
    tbl[17] = '{3'b010, 6'd8, 32'h0,        6'h0F, 3'b000};
    tbl[18] = '{3'b000, 6'd0, 32'h0,        6'h0F, 3'b010};
    tbl[19] = '{3'b001, 6'd0, 32'hBFC00380, 6'h00, 3'b110};
    tbl[20] = '{3'b000, 6'd0, 32'h0,        6'h00, 3'b000};

    rst = 1'b1;
    drive(1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
    @(negedge clk);
    do_reset("reset0");

    // Watchdog: a 3-cycle hold must not trip, a 4-cycle hold must, and it stays set.
    for (int i = 0; i < 3; i++) step("wd3", 1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
    step("wd_gap", 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
    chk("wd_no_trip", 32'(stall_timeout), 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("wd_pre_trip", 32'(stall_timeout), 32'h0);
      step("wd4", 1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
    end
    chk("wd_trip", 32'(stall_timeout), 32'h1);
    step("wd_after", 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
    chk("wd_sticky", 32'(stall_timeout), 32'h1);

    // Directed vector table.
    do_reset("reset1");
    for (int i = 0; i < 21; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (i == 3) chk("id_hazard_cycles", 32'(stall_cycles), 32'd2);
      apply(tag, tbl[i].req[2], tbl[i].req[1], tbl[i].cy, tbl[i].req[0], tbl[i].pc);
      chk({tag, ".tbl_stall"}, 32'(stall), 32'(tbl[i].e_stall));
      chk({tag, ".tbl_ctl"}, 32'({flush, ex_mc_busy, ex_mc_last}), 32'(tbl[i].e_out));
      chk({tag, ".tbl_pc"}, new_pc, tbl[i].req[0] ? tbl[i].pc : 32'h0);
      advance();
    end

    // Reset asserted in the middle of a 10-cycle op.
    do_reset("reset2");
    step("mid_start", 1'b0, 1'b1, 6'd10, 1'b0, 32'h0);
    step("mid_run1", 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
    step("mid_run2", 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
    chk("mid_busy_before", 32'(ex_mc_busy), 32'h1);
    #2;
    drive(1'b0, 1'b0, 6'd0, 1'b1, 32'hBFC00380);
    rst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    drive(1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
    m_owed = 0; m_run = 0; m_cyc = 0; m_to = 1'b0;
    rst = 1'b1;
    step("mid_released", 1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
    chk("mid_idle_stall", 32'(stall), 32'h0);
    chk("mid_idle_busy", 32'(ex_mc_busy), 32'h0);

    // Randomized traffic against the model.
    do_reset("reset3");
    for (int i = 0; i < 600; i++) begin
      logic sr, st, fl;
      sr = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 5) == 0);
      fl = ($urandom_range(0, 15) == 0);
      step($sformatf("rnd%0d", i), sr, st, 6'($urandom_range(0, 12)), fl, $urandom);
    end

    // Performance counter saturation.
    do_reset("reset4");
    for (int i = 0; i < 260; i++) step("sat", 1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
    chk("sat_value", 32'(stall_cycles), 32'(PERF_MAX));
    step("sat_hold", 1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
    chk("sat_no_wrap", 32'(stall_cycles), 32'(PERF_MAX));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
